// File: rtl/axis_rr_mux.sv
// AXI-Stream N:1 packet multiplexer with round-robin arbitration.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no channel owns the output; pick next requester round-robin
// ST_LOCKED | granted channel owns the output until its tlast is accepted
//
// Each accepted input beat is captured in a single output register stage,
// so data appears on the master side one cycle after acceptance. The grant
// is held for a whole packet. Every packet boundary costs one IDLE cycle,
// which is spent picking the next channel.
module axis_rr_mux #(
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = 4,
  parameter int NUM_CH    = 4,
  parameter int TID_MODE  = 0
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic [NUM_CH-1:0]             s_tvalid,
  output logic [NUM_CH-1:0]             s_tready,
  input  logic [NUM_CH-1:0]             s_tlast,
  input  logic [NUM_CH*DATA_SIZE-1:0]   s_tdata,
  input  logic [NUM_CH*ID_SIZE-1:0]     s_tid,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [DATA_SIZE-1:0]          m_tdata,
  output logic [ID_SIZE-1:0]            m_tid
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        w_grant_nxt;
  logic [GW-1:0]        r_last_grant;
  logic [GW-1:0]        w_last_grant_nxt;
  logic [GW-1:0]        w_rr_sel;
  logic                 w_rr_found;
  logic                 w_out_free;
  logic                 w_accept;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [DATA_SIZE-1:0] w_sel_data;
  logic [ID_SIZE-1:0]   w_sel_tid;
  logic [ID_SIZE-1:0]   w_tid_out;

  logic                 r_m_tvalid;
  logic                 r_m_tlast;
  logic [DATA_SIZE-1:0] r_m_tdata;
  logic [ID_SIZE-1:0]   r_m_tid;

  // Round-robin search: first requesting channel after the last granted one.
  always_comb begin
    int v_idx;
    w_rr_sel   = r_last_grant;
    w_rr_found = 1'b0;
    v_idx      = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      v_idx = (int'(r_last_grant) + i) % NUM_CH;
      if (!w_rr_found && s_tvalid[v_idx[GW-1:0]]) begin
        w_rr_sel   = v_idx[GW-1:0];
        w_rr_found = 1'b1;
      end
    end
  end

  // Mux the granted channel's sideband and payload; other channels are ignored.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_tid   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_grant == GW'(k)) begin
        w_sel_valid = s_tvalid[k];
        w_sel_last  = s_tlast[k];
        w_sel_data  = s_tdata[k*DATA_SIZE +: DATA_SIZE];
        w_sel_tid   = s_tid[k*ID_SIZE +: ID_SIZE];
      end
    end
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_free = !r_m_tvalid || m_tready;

  // Channel index or passthrough tid, chosen at elaboration.
  assign w_tid_out = (TID_MODE != 0) ? w_sel_tid : ID_SIZE'(r_grant);

  // Next-state, grant bookkeeping and slave-side ready.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_accept         = 1'b0;
    s_tready         = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_found) begin
          w_grant_nxt = w_rr_sel;
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        s_tready = w_out_free ? (NUM_CH'(1) << r_grant) : '0;
        w_accept = w_sel_valid && w_out_free;
        if (w_accept && w_sel_last) begin
          w_last_grant_nxt = r_grant;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbiter state; after reset channel 0 is first in line.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_CH - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Output beat register: load on accept, otherwise hold until drained.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_sel_last;
      r_m_tdata  <= w_sel_data;
      r_m_tid    <= w_tid_out;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign m_tdata  = r_m_tdata;
  assign m_tid    = r_m_tid;

endmodule
